// File: rtl/minifloat_packer.sv
// Packs 7-bit minifloat codes four to a 28-bit word, with flush of partial words.
// Optional MINIFLOAT_PACKER_PARITY_EN adds a registered even-parity output.
module minifloat_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [6:0]  in_code,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [27:0] out_data,
    output logic [2:0]  out_count,
    input  logic        out_ready,
`ifdef MINIFLOAT_PACKER_PARITY_EN
    output logic        out_parity,
`endif
    output logic [15:0] out_words
);

    logic [20:0] acc_q, acc_d;
    logic [1:0]  acc_cnt_q, acc_cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic        out_valid_q, out_valid_d;
    logic [27:0] out_data_q, out_data_d;
    logic [2:0]  out_count_q, out_count_d;
    logic [15:0] out_words_q, out_words_d;
    logic        out_parity_q, out_parity_d;

    logic        out_free;
    logic        accept;
    logic        full_load;
    logic        flush_act;
    logic        part_emit;
    logic [20:0] acc_eff;
    logic [2:0]  cnt_eff;
    logic [27:0] load_data;
    logic [2:0]  load_cnt;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = rst_n && ((acc_cnt_q != 2'd3) || out_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_eff   = acc_q;
        cnt_eff   = {1'b0, acc_cnt_q};
        if (accept && (acc_cnt_q != 2'd3)) begin
            unique case (acc_cnt_q)
                2'd0:    acc_eff[6:0]   = in_code;
                2'd1:    acc_eff[13:7]  = in_code;
                default: acc_eff[20:14] = in_code;
            endcase
            cnt_eff = {1'b0, acc_cnt_q} + 3'd1;
        end

        // A full-word load implies the output register is free (in_ready).
        full_load = accept && (acc_cnt_q == 2'd3);
        flush_act = flush || flush_pend_q;
        part_emit = flush_act && (cnt_eff != 3'd0) && out_free && !full_load;

        if (full_load) begin
            load_data = {in_code, acc_q};
            load_cnt  = 3'd4;
        end else begin
            load_data = {7'd0, acc_eff};
            load_cnt  = cnt_eff;
        end

        acc_d     = acc_eff;
        acc_cnt_d = cnt_eff[1:0];
        if (full_load || part_emit) begin
            acc_d     = 21'd0;
            acc_cnt_d = 2'd0;
        end

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_parity_d = out_parity_q;
        if (full_load || part_emit) begin
            out_valid_d  = 1'b1;
            out_data_d   = load_data;
            out_count_d  = load_cnt;
            // Unused lanes are zero, so whole-word parity equals lane parity.
            out_parity_d = ^load_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        out_words_d = out_words_q;
        if (out_valid_q && out_ready) begin
            out_words_d = out_words_q + 16'd1;
        end

        flush_pend_d = flush_pend_q;
        if (full_load || part_emit) begin
            flush_pend_d = 1'b0;
        end else if (flush_act && (cnt_eff == 3'd0)) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q        <= 21'd0;
            acc_cnt_q    <= 2'd0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 28'd0;
            out_count_q  <= 3'd0;
            out_words_q  <= 16'd0;
            out_parity_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_words_q  <= out_words_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_words = out_words_q;

`ifdef MINIFLOAT_PACKER_PARITY_EN
    assign out_parity = out_parity_q;
`else
    logic unused_parity;
    assign unused_parity = out_parity_q;
`endif

endmodule
